// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for decode_stage.
// in_*  : fetch presents one raw instruction word with its PC (valid/ready).
// out_* : head entry of the decoded-bundle queue presented to execute (valid/ready).
// Modports: master = fetch/execute side, slave = decode stage.
// Optional macro DECODE_M_EN adds out_is_muldiv.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [8:0]      out_flags;
  logic [3:0]      out_alu_op;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [1:0]      out_mem_size;
  logic            out_mem_unsigned;
  logic            out_is_word_op;
  logic            out_illegal;
`ifdef DECODE_M_EN
  logic            out_is_muldiv;
`endif

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_flags, out_alu_op, out_rd, out_rs1, out_rs2,
    input  out_imm, out_mem_size, out_mem_unsigned, out_is_word_op, out_illegal
`ifdef DECODE_M_EN
    , input out_is_muldiv
`endif
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_flags, out_alu_op, out_rd, out_rs1, out_rs2,
    output out_imm, out_mem_size, out_mem_unsigned, out_is_word_op, out_illegal
`ifdef DECODE_M_EN
    , output out_is_muldiv
`endif
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: decodes each accepted word into a bundle and queues it in a
// DEPTH-entry FIFO. A RUN/HALTED FSM stops acceptance after ECALL, EBREAK or an illegal
// word until flush. illegal_count saturates at all-ones.
// Ports: clk, rst_n (async active-low), flush (sync drop + resume), bus (decode_stage_if.slave),
//        illegal_count.
// Optional macro DECODE_M_EN: decode the M extension and drive out_is_muldiv.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] illegal_count
);
  localparam bit Is64 = (XLEN == 64);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  localparam int unsigned FlUseImm = 0;
  localparam int unsigned FlPcSrc1 = 1;
  localparam int unsigned FlBranch = 2;
  localparam int unsigned FlNextPc = 3;
  localparam int unsigned FlZero   = 4;
  localparam int unsigned FlRamRd  = 5;
  localparam int unsigned FlRamWr  = 6;
  localparam int unsigned FlEbreak = 7;
  localparam int unsigned FlEcall  = 8;

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  typedef struct packed {
`ifdef DECODE_M_EN
    logic            is_muldiv;
`endif
    logic [XLEN-1:0] pc;
    logic [8:0]      flags;
    logic [3:0]      alu_op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            is_word_op;
    logic            illegal;
  } bundle_t;

  // ---------------------------------------------------------------------------------------------
  // Decoder
  // ---------------------------------------------------------------------------------------------
  logic [31:0] instr, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic        word;
  logic signed [31:0] imm32;
  logic        ill;
  bundle_t     dec;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign word   = opcode[3];  // distinguishes OP-32/OP-IMM-32 from OP/OP-IMM
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec    = '0;
    dec.pc = bus.in_pc;
    imm32  = '0;
    ill    = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111: begin  // LUI, AUIPC
        dec.flags[FlUseImm] = 1'b1;
        dec.flags[FlPcSrc1] = opcode[5] == 1'b0;
        dec.rd              = instr[11:7];
        imm32               = imm_u;
      end
      7'b1101111, 7'b1100111: begin  // JAL, JALR
        dec.flags[FlBranch] = 1'b1;
        dec.flags[FlNextPc] = 1'b1;
        dec.flags[FlZero]   = 1'b1;
        dec.rd              = instr[11:7];
        if (opcode[3]) begin
          imm32 = imm_j;
        end else begin
          dec.flags[FlUseImm] = 1'b1;
          dec.rs1             = instr[19:15];
          imm32               = imm_i;
          ill                 = f3 != 3'b000;
        end
      end
      7'b1100011: begin  // branches: zero-test is BEQ/BGE/BGEU
        ill                 = f3[2:1] == 2'b01;
        dec.flags[FlBranch] = 1'b1;
        dec.flags[FlZero]   = ~(f3[2] ^ f3[0]);
        dec.alu_op          = f3[2] ? {3'b001, f3[1]} : 4'b1000;
        dec.rs1             = instr[19:15];
        dec.rs2             = instr[24:20];
        imm32               = imm_b;
      end
      7'b0000011: begin  // loads
        ill = (f3 == 3'b111) || (!Is64 && (f3 == 3'b011 || f3 == 3'b110));
        dec.flags[FlRamRd]  = 1'b1;
        dec.flags[FlUseImm] = 1'b1;
        dec.rd              = instr[11:7];
        dec.rs1             = instr[19:15];
        dec.mem_size        = f3[1:0];
        dec.mem_unsigned    = f3[2];
        imm32               = imm_i;
      end
      7'b0100011: begin  // stores
        ill = f3[2] || (!Is64 && f3[1:0] == 2'b11);
        dec.flags[FlRamWr]  = 1'b1;
        dec.flags[FlUseImm] = 1'b1;
        dec.rs1             = instr[19:15];
        dec.rs2             = instr[24:20];
        dec.mem_size        = f3[1:0];
        imm32               = imm_s;
      end
      7'b0010011, 7'b0011011: begin  // OP-IMM, OP-IMM-32
        ill                 = word && !Is64;
        dec.is_word_op      = word;
        dec.flags[FlUseImm] = 1'b1;
        dec.rd              = instr[11:7];
        dec.rs1             = instr[19:15];
        dec.alu_op          = {1'b0, f3};
        imm32               = imm_i;
        case (f3)
          3'b001: begin
            ill   = ill || (instr[31:26] != 6'd0) || ((!Is64 || word) && instr[25]);
            imm32 = {26'd0, instr[25:20]};
          end
          3'b101: begin
            ill        = ill || ({instr[31], instr[29:26]} != 5'd0) ||
                         ((!Is64 || word) && instr[25]);
            dec.alu_op = {instr[30], f3};
            imm32      = {26'd0, instr[25:20]};
          end
          default: ill = ill || (word && f3 != 3'b000);
        endcase
      end
      7'b0110011, 7'b0111011: begin  // OP, OP-32
        ill            = word && !Is64;
        dec.is_word_op = word;
        dec.rd         = instr[11:7];
        dec.rs1        = instr[19:15];
        dec.rs2        = instr[24:20];
        dec.alu_op     = {f7[5], f3};
        if (f7 == 7'b0000000) begin
          ill = ill || (word && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101));
        end else if (f7 == 7'b0100000) begin
          ill = ill || !(f3 == 3'b000 || f3 == 3'b101);
`ifdef DECODE_M_EN
        end else if (f7 == 7'b0000001) begin
          dec.alu_op    = {1'b1, f3};
          dec.is_muldiv = 1'b1;
          ill = ill || (word && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011));
`endif
        end else begin
          ill = 1'b1;
        end
      end
      7'b1110011: begin  // only exact ECALL/EBREAK words are legal
        if (instr == 32'h0000_0073) begin
          dec.flags[FlEcall] = 1'b1;
        end else if (instr == 32'h0010_0073) begin
          dec.flags[FlEbreak] = 1'b1;
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    dec.imm = XLEN'(imm32);
    if (ill) begin
      dec                 = '0;
      dec.pc              = bus.in_pc;
      dec.flags[FlUseImm] = 1'b1;
      dec.illegal         = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Queue, FSM, counter
  // ---------------------------------------------------------------------------------------------
  bundle_t          mem_q [DEPTH];
  bundle_t          head;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  state_e           state_q, state_d;
  logic             accept, pop;

  // rst_n gates in_ready so fetch sees no capacity while reset is held.
  assign bus.in_ready  = rst_n && (state_q == StRun) && (cnt_q < CntFull) && !flush;
  assign bus.out_valid = cnt_q != '0;
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready && !flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      state_d  = StRun;
    end else begin
      if (accept) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      case ({accept, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (accept && (dec.illegal || dec.flags[FlEcall] || dec.flags[FlEbreak])) begin
        state_d = StHalted;
      end
      if (accept && dec.illegal && ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ill_cnt_q <= '0;
      state_q   <= StRun;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ill_cnt_q <= ill_cnt_d;
      state_q   <= state_d;
    end
  end

  // Storage needs no reset: outputs are forced to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= dec;
  end

  assign head                 = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.out_pc           = head.pc;
  assign bus.out_flags        = head.flags;
  assign bus.out_alu_op       = head.alu_op;
  assign bus.out_rd           = head.rd;
  assign bus.out_rs1          = head.rs1;
  assign bus.out_rs2          = head.rs2;
  assign bus.out_imm          = head.imm;
  assign bus.out_mem_size     = head.mem_size;
  assign bus.out_mem_unsigned = head.mem_unsigned;
  assign bus.out_is_word_op   = head.is_word_op;
  assign bus.out_illegal      = head.illegal;
`ifdef DECODE_M_EN
  assign bus.out_is_muldiv    = head.is_muldiv;
`endif
  assign illegal_count        = ill_cnt_q;
endmodule
